// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: grant encoding and default widths shared by the write-back arbiter files
package riscv_wb_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_STARVE_LIMIT = 4;
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LL   = 2'd2
  } gnt_e;
endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// riscv_wb_arbiter_if: ALU / long-latency result inputs and register-file write port
interface riscv_wb_arbiter_if
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_WIDTH-1:0]    alu_addr;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     ll_valid;
  logic                     ll_ready;
  logic [ADDR_WIDTH-1:0]    ll_addr;
  logic [DATA_WIDTH-1:0]    ll_data;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [2**ADDR_WIDTH-1:0] pending;
  modport master (
    output alu_valid, alu_addr, alu_data, ll_valid, ll_addr, ll_data,
    input  alu_ready, ll_ready, wr_en, wr_addr, wr_data, pending
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, ll_valid, ll_addr, ll_data,
    output alu_ready, ll_ready, wr_en, wr_addr, wr_data, pending
  );
endinterface

// File: rtl/riscv_wb_fifo.sv
// riscv_wb_fifo: in-order buffer of long-latency results exposing per-entry destinations
module riscv_wb_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [ADDR_WIDTH-1:0]   i_push_addr,
  input  logic [DATA_WIDTH-1:0]   i_push_data,
  input  logic                    i_pop,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [ADDR_WIDTH-1:0]   o_head_addr,
  output logic [DATA_WIDTH-1:0]   o_head_data,
  output logic [ADDR_WIDTH-1:0]   o_addr [DEPTH],
  output logic [DEPTH-1:0]        o_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PW-1:0]         r_wp, r_rp;
  logic [CW-1:0]         r_count;
  // Payload storage needs no reset; the valid bits and count gate everything observable.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wp] <= i_push_addr;
      r_data[r_wp] <= i_push_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) begin
        r_valid[r_rp] <= 1'b0;
        r_rp          <= r_rp + PW'(1);
      end
      if (i_push) begin
        r_valid[r_wp] <= 1'b1;
        r_wp          <= r_wp + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_count     = r_count;
  assign o_head_addr = r_addr[r_rp];
  assign o_head_data = r_data[r_rp];
  assign o_addr      = r_addr;
  assign o_valid     = r_valid;
endmodule

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: merges ALU and buffered long-latency results onto one register-file write port
module riscv_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic              clk,
  input logic              rst,
  riscv_wb_arbiter_if.slave bus
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AGW-1:0] LIMIT_C = AGW'(STARVE_LIMIT);
  logic [CW-1:0]            w_count, w_count_nxt;
  logic [ADDR_WIDTH-1:0]    w_head_addr, w_sel_addr;
  logic [DATA_WIDTH-1:0]    w_head_data, w_sel_data;
  logic [ADDR_WIDTH-1:0]    w_ent_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    w_ent_valid;
  logic [AGW-1:0]           r_age, w_age_nxt;
  logic                     r_starve;
  logic                     w_push, w_pop, w_nonempty, w_ll_ready, w_alu_ready;
  gnt_e                     w_gnt;
  logic                     r_wr_en;
  logic [ADDR_WIDTH-1:0]    r_wr_addr;
  logic [DATA_WIDTH-1:0]    r_wr_data;
  logic [2**ADDR_WIDTH-1:0] w_pending;
  riscv_wb_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_addr(bus.ll_addr),
    .i_push_data(bus.ll_data),
    .i_pop      (w_pop),
    .o_count    (w_count),
    .o_head_addr(w_head_addr),
    .o_head_data(w_head_data),
    .o_addr     (w_ent_addr),
    .o_valid    (w_ent_valid)
  );
  // Starved head preempts the ALU; otherwise the ALU wins and the FIFO takes idle slots.
  always_comb begin
    w_nonempty  = w_count != '0;
    w_ll_ready  = !rst && (w_count < DEPTH_C);
    w_alu_ready = !rst && !r_starve;
    w_push      = bus.ll_valid && w_ll_ready;
    w_gnt       = r_starve ? GNT_LL : bus.alu_valid ? GNT_ALU : w_nonempty ? GNT_LL : GNT_NONE;
    w_pop       = w_gnt == GNT_LL;
    w_sel_addr  = (w_gnt == GNT_ALU) ? bus.alu_addr : w_head_addr;
    w_sel_data  = (w_gnt == GNT_ALU) ? bus.alu_data : w_head_data;
    w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
    w_age_nxt   = (w_pop || !w_nonempty) ? '0 : (r_age == LIMIT_C) ? r_age : r_age + AGW'(1);
  end
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (w_ent_valid[i]) w_pending[w_ent_addr[i]] = 1'b1;
    w_pending[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age     <= '0;
      r_starve  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_age    <= w_age_nxt;
      r_starve <= (w_count_nxt != '0) && (w_age_nxt >= LIMIT_C);
      r_wr_en  <= (w_gnt != GNT_NONE) && (w_sel_addr != '0);
      if (w_gnt != GNT_NONE) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
      end
    end
  end
  assign bus.ll_ready  = w_ll_ready;
  assign bus.alu_ready = w_alu_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.pending   = w_pending;
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb_riscv_wb_arbiter: directed checks of arbitration, ageing, x0 handling and reset
module tb_riscv_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  riscv_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  riscv_wb_arbiter #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (5),
    .FIFO_DEPTH  (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.ll_valid  = 1'b0;
    bus.ll_addr   = '0;
    bus.ll_data   = '0;
    cyc;
    cyc;
    chk("rst_alu_ready", bus.alu_ready, 0);
    chk("rst_ll_ready", bus.ll_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_pending", bus.pending, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_alu_ready", bus.alu_ready, 1);
    chk("post_rst_ll_ready", bus.ll_ready, 1);
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd5;
    bus.alu_data  = 32'h1234;
    cyc;
    bus.alu_valid = 1'b0;
    #1;
    chk("alu_wr_en", bus.wr_en, 1);
    chk("alu_wr_addr", bus.wr_addr, 5);
    chk("alu_wr_data", bus.wr_data, 32'h1234);
    chk("alu_ll_ready", bus.ll_ready, 1);
    cyc;
    chk("alu_wr_en_drop", bus.wr_en, 0);
    chk("alu_wr_addr_hold", bus.wr_addr, 5);
    bus.ll_valid = 1'b1;
    bus.ll_addr  = 5'd10;
    bus.ll_data  = 32'hDEAD;
    #1;
    chk("ll_ready", bus.ll_ready, 1);
    cyc;
    bus.ll_valid = 1'b0;
    #1;
    chk("ll_pending_set", bus.pending, 32'h400);
    chk("ll_no_bypass", bus.wr_en, 0);
    cyc;
    chk("ll_wr_en", bus.wr_en, 1);
    chk("ll_wr_addr", bus.wr_addr, 10);
    chk("ll_wr_data", bus.wr_data, 32'hDEAD);
    chk("ll_pending_clr", bus.pending, 0);
    cyc;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd20;
    bus.alu_data  = 32'hA0;
    bus.ll_valid  = 1'b1;
    bus.ll_addr   = 5'd3;
    bus.ll_data   = 32'h333;
    cyc;
    bus.ll_addr = 5'd4;
    bus.ll_data = 32'h444;
    #1;
    chk("full_second_push_ready", bus.ll_ready, 1);
    cyc;
    bus.ll_valid = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      if (k > 2) cyc;
      #1;
      chk($sformatf("full_alu_ready_%0d", k), bus.alu_ready, !(k == 5 || k == 10));
      chk($sformatf("full_ll_ready_%0d", k), bus.ll_ready, k >= 6);
      chk($sformatf("full_pending_%0d", k), bus.pending, k <= 5 ? 32'h18 : k <= 10 ? 32'h10 : 32'h0);
      chk($sformatf("full_wr_en_%0d", k), bus.wr_en, 1);
      chk($sformatf("full_wr_addr_%0d", k), bus.wr_addr, k == 6 ? 3 : k == 11 ? 4 : 20);
      chk($sformatf("full_wr_data_%0d", k), bus.wr_data, k == 6 ? 32'h333 : k == 11 ? 32'h444 : 32'hA0);
    end
    bus.alu_valid = 1'b0;
    cyc;
    chk("full_idle_wr_en", bus.wr_en, 0);
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd0;
    bus.alu_data  = 32'hFFFF;
    #1;
    chk("x0_alu_ready", bus.alu_ready, 1);
    cyc;
    bus.alu_valid = 1'b0;
    bus.ll_valid  = 1'b1;
    bus.ll_addr   = 5'd0;
    bus.ll_data   = 32'h55;
    #1;
    chk("x0_alu_wr_en", bus.wr_en, 0);
    chk("x0_alu_wr_addr", bus.wr_addr, 0);
    chk("x0_alu_wr_data", bus.wr_data, 32'hFFFF);
    cyc;
    bus.ll_valid = 1'b0;
    #1;
    chk("x0_ll_pending", bus.pending, 0);
    chk("x0_ll_wr_en_wait", bus.wr_en, 0);
    cyc;
    chk("x0_ll_wr_en", bus.wr_en, 0);
    chk("x0_ll_popped_data", bus.wr_data, 32'h55);
    chk("x0_ll_pending_after", bus.pending, 0);
    for (int j = 0; j <= 9; j++) begin
      if (j < 8) begin
        bus.ll_valid = 1'b1;
        bus.ll_addr  = 5'(j + 1);
        bus.ll_data  = 32'(32'h100 + j + 1);
      end else bus.ll_valid = 1'b0;
      #1;
      chk($sformatf("wrap_ll_ready_%0d", j), bus.ll_ready, 1);
      if (j >= 1) chk($sformatf("wrap_pending_%0d", j), bus.pending, j <= 8 ? 32'(1) << j : 32'h0);
      if (j >= 2) begin
        chk($sformatf("wrap_wr_en_%0d", j), bus.wr_en, 1);
        chk($sformatf("wrap_wr_addr_%0d", j), bus.wr_addr, j - 1);
        chk($sformatf("wrap_wr_data_%0d", j), bus.wr_data, 32'h100 + j - 1);
      end
      cyc;
    end
    chk("wrap_done_wr_en", bus.wr_en, 0);
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd21;
    bus.alu_data  = 32'h21;
    bus.ll_valid  = 1'b1;
    bus.ll_addr   = 5'd7;
    bus.ll_data   = 32'h777;
    cyc;
    bus.ll_addr = 5'd9;
    bus.ll_data = 32'h999;
    cyc;
    bus.ll_valid  = 1'b0;
    bus.alu_valid = 1'b0;
    #1;
    chk("mid_pending_before", bus.pending, 32'h280);
    rst = 1'b1;
    #1;
    chk("mid_rst_alu_ready", bus.alu_ready, 0);
    chk("mid_rst_ll_ready", bus.ll_ready, 0);
    cyc;
    rst = 1'b0;
    #1;
    chk("mid_wr_en", bus.wr_en, 0);
    chk("mid_pending", bus.pending, 0);
    chk("mid_ll_ready", bus.ll_ready, 1);
    for (int n = 0; n < 5; n++) begin
      cyc;
      chk($sformatf("mid_discard_wr_en_%0d", n), bus.wr_en, 0);
      chk($sformatf("mid_discard_pending_%0d", n), bus.pending, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
